// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array host-side stream controller.
package systolic_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_K      = 4;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    DRAIN
  } state_t;

  // Row-major flat index to the LSB of that element inside a packed bus.
  function automatic int elem_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/systolic_result_serializer.sv
// Captures the core's packed C result and streams it out row-major over valid/ready.
import systolic_pkg::*;

module systolic_result_serializer #(
  parameter int ACC_W = DEF_ACC_W,
  parameter int N     = DEF_ROWS * DEF_COLS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [N*ACC_W-1:0] c_flat,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [ACC_W-1:0] m_data,
  output logic             m_last,
  output logic             drain_done
);

  localparam int IDX_W = $clog2(N + 1);

  logic [N*ACC_W-1:0] c_buf;
  logic [IDX_W-1:0]   idx;
  logic               active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_buf  <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (capture) begin
      c_buf  <= c_flat;
      idx    <= '0;
      active <= 1'b1;
    end else if (active && m_ready) begin
      if (m_last) begin
        active <= 1'b0;
        idx    <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Index only moves on a handshake, so data/last hold while stalled.
  assign m_valid    = active;
  assign m_data     = c_buf[elem_lsb(int'(idx), ACC_W) +: ACC_W];
  assign m_last     = active && (idx == IDX_W'(N - 1));
  assign drain_done = active && m_ready && m_last;

endmodule

// File: rtl/systolic_stream_ctrl.sv
// Host-side initiator: loads A then B from a stream, kicks the core, drains C as a stream.
// Optional start-to-done cycle counter enabled by defining SYSTOLIC_CYCLE_COUNT_EN.
import systolic_pkg::*;

module systolic_stream_ctrl #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int K      = DEF_K
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [ACC_W-1:0]           m_data,
  output logic                       m_last,
  output logic                       core_start,
  input  logic                       core_busy,
  input  logic                       core_done,
  output logic [ROWS*K*DATA_W-1:0]   a_flat,
  output logic [K*COLS*DATA_W-1:0]   b_flat,
  input  logic [ROWS*COLS*ACC_W-1:0] c_flat,
  output logic                       ctrl_busy,
  output logic [31:0]                cycle_count
);

  localparam int NA     = ROWS * K;
  localparam int NB     = K * COLS;
  localparam int NC     = ROWS * COLS;
  localparam int LOAD_N = (NA > NB) ? NA : NB;
  localparam int IDX_W  = $clog2(LOAD_N + 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             capture;
  logic             drain_done;
  logic             busy_unused;

  // Sequencing relies on core_done alone; busy is observed only.
  assign busy_unused = core_busy;

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    core_start = 1'b0;
    capture    = 1'b0;
    ctrl_busy  = 1'b1;
    case (state)
      LOAD_A: begin
        s_ready   = 1'b1;
        ctrl_busy = (idx != '0);
        if (s_valid && idx == IDX_W'(NA - 1)) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        s_ready = 1'b1;
        if (s_valid && idx == IDX_W'(NB - 1)) state_nxt = START;
      end
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  assign accept = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) idx <= (state_nxt != state) ? '0 : idx + 1'b1;
    end
  end

  // Operand buffers only change on accepted beats, so they stay stable through the core run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_flat <= '0;
      b_flat <= '0;
    end else if (accept) begin
      if (state == LOAD_A) a_flat[elem_lsb(int'(idx), DATA_W) +: DATA_W] <= s_data;
      else                 b_flat[elem_lsb(int'(idx), DATA_W) +: DATA_W] <= s_data;
    end
  end

  systolic_result_serializer #(
    .ACC_W (ACC_W),
    .N     (NC)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (capture),
    .c_flat     (c_flat),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .drain_done (drain_done)
  );

`ifdef SYSTOLIC_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;

  // Counts every WAIT cycle including the done cycle, then freezes once WAIT is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cyc_cnt <= '0;
    else if (core_start)                     cyc_cnt <= '0;
    else if (state == WAIT && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
  end

  assign cycle_count = cyc_cnt;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_systolic_stream_ctrl.sv
// Scoreboard bench for systolic_stream_ctrl with a behavioural matrix-multiply core stub.
`timescale 1ns/1ps

module tb_systolic_stream_ctrl;

  localparam int DATA_W   = 8;
  localparam int ACC_W    = 32;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int K        = 4;
  localparam int NE       = 16;
  localparam int CORE_DLY = 10;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       s_valid;
  logic                       s_ready;
  logic [DATA_W-1:0]          s_data;
  logic                       m_valid;
  logic                       m_ready;
  logic [ACC_W-1:0]           m_data;
  logic                       m_last;
  logic                       core_start;
  logic                       core_busy;
  logic                       core_done;
  logic [ROWS*K*DATA_W-1:0]   a_flat;
  logic [K*COLS*DATA_W-1:0]   b_flat;
  logic [ROWS*COLS*ACC_W-1:0] c_flat;
  logic                       ctrl_busy;
  logic [31:0]                cycle_count;

  always #5 clk = ~clk;

  systolic_stream_ctrl #(
    .DATA_W (DATA_W), .ACC_W (ACC_W), .ROWS (ROWS), .COLS (COLS), .K (K)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .core_start  (core_start),
    .core_busy   (core_busy),
    .core_done   (core_done),
    .a_flat      (a_flat),
    .b_flat      (b_flat),
    .c_flat      (c_flat),
    .ctrl_busy   (ctrl_busy),
    .cycle_count (cycle_count)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   starts_seen = 0;
  bit   rdy_toggle = 1'b0;
  int   ma[NE];
  int   mb[NE];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [NE*ACC_W-1:0] matmul(input logic [ROWS*K*DATA_W-1:0] a,
                                                  input logic [K*COLS*DATA_W-1:0] b);
    logic [NE*ACC_W-1:0] c;
    int acc;
    c = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int col = 0; col < COLS; col++) begin
        acc = 0;
        for (int kk = 0; kk < K; kk++)
          acc += int'($signed(a[(r*K+kk)*DATA_W +: DATA_W])) *
                 int'($signed(b[(kk*COLS+col)*DATA_W +: DATA_W]));
        c[(r*COLS+col)*ACC_W +: ACC_W] = 32'(acc);
      end
    end
    return c;
  endfunction

  // Core stub: done pulse CORE_DLY cycles after the start cycle.
  initial begin
    core_done = 1'b0;
    core_busy = 1'b0;
    c_flat    = '0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        core_busy = 1'b1;
        repeat (CORE_DLY) @(posedge clk);
        #1;
        c_flat    = matmul(a_flat, b_flat);
        core_done = 1'b1;
        core_busy = 1'b0;
        @(posedge clk);
        #1;
        core_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) starts_seen++;
    end
  end

  // Downstream ready: steady, or the 1,0,0,1 pattern.
  initial begin
    int k;
    k = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) begin
        m_ready = ((k % 4) == 0) || ((k % 4) == 3);
        k++;
      end else begin
        m_ready = 1'b1;
        k = 0;
      end
    end
  end

  // Monitor: pops expected results on each handshake, checks stall stability.
  initial begin
    exp_t        e;
    logic        stalled;
    logic        after_last;
    logic [31:0] pd;
    logic        pl;
    stalled    = 1'b0;
    after_last = 1'b0;
    pd         = '0;
    pl         = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        stalled    = 1'b0;
        after_last = 1'b0;
      end else begin
        if (after_last) begin
          check("idle_m_valid", 64'(m_valid), 64'(0));
          check("idle_s_ready", 64'(s_ready), 64'(1));
          after_last = 1'b0;
        end
        if (stalled) begin
          check("stall_m_valid", 64'(m_valid), 64'(1));
          check("stall_m_data", 64'(m_data), 64'(pd));
          check("stall_m_last", 64'(m_last), 64'(pl));
        end
        stalled = 1'b0;
        if (m_valid === 1'b1) begin
          check("drain_s_ready", 64'(s_ready), 64'(0));
          if (m_ready) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_output: got 0x%0h, required no output", m_data);
            end else begin
              e = exp_q.pop_front();
              check("m_data", 64'(m_data), 64'(e.data));
              check("m_last", 64'(m_last), 64'(e.last));
              if (m_last) after_last = 1'b1;
            end
          end else begin
            stalled = 1'b1;
            pd      = m_data;
            pl      = m_last;
          end
        end
      end
    end
  end

  task automatic send_beat(input int v);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = DATA_W'(v);
    @(negedge clk);
    while (s_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (s_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL s_ready_timeout: got s_ready=%b, required 1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic load_mats();
    for (int i = 0; i < NE; i++) begin
      send_beat(ma[i]);
      if (i == 0) check("ctrl_busy_loading", 64'(ctrl_busy), 64'(1));
    end
    for (int i = 0; i < NE; i++) send_beat(mb[i]);
    @(negedge clk);
    check("core_start_after_last_beat", 64'(core_start), 64'(1));
    check("s_ready_in_start", 64'(s_ready), 64'(0));
    @(negedge clk);
    check("core_start_one_cycle", 64'(core_start), 64'(0));
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_drain_timeout: %0d outputs outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
`ifdef SYSTOLIC_CYCLE_COUNT_EN
    check("cycle_count", 64'(cycle_count), 64'(CORE_DLY));
`else
    check("cycle_count", 64'(cycle_count), 64'(0));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic set_identity_a();
    for (int i = 0; i < NE; i++) ma[i] = ((i / K) == (i % K)) ? 1 : 0;
  endtask

  task automatic push_exp(input int v, input int i);
    exp_t e;
    e.data = 32'(v);
    e.last = (i == NE - 1);
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(s_ready), 64'(1));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_core_start", 64'(core_start), 64'(0));
    check("rst_ctrl_busy", 64'(ctrl_busy), 64'(0));
    check("rst_cycle_count", 64'(cycle_count), 64'(0));
    check("rst_a_flat", 64'(a_flat[63:0]), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Identity times 1..16
    set_identity_a();
    for (int i = 0; i < NE; i++) begin
      mb[i] = i + 1;
      push_exp(i + 1, i);
    end
    load_mats();
    wait_drain("identity");

    // All 2 times all 3
    for (int i = 0; i < NE; i++) begin
      ma[i] = 2;
      mb[i] = 3;
      push_exp(24, i);
    end
    load_mats();
    wait_drain("const");

    // Back-pressure during drain, signed values through identity
    rdy_toggle = 1'b1;
    set_identity_a();
    for (int i = 0; i < NE; i++) begin
      mb[i] = 50 - 9 * i;
      push_exp(50 - 9 * i, i);
    end
    load_mats();
    wait_drain("stall");
    rdy_toggle = 1'b0;

    // Signed corner: -128 * 127
    for (int i = 0; i < NE; i++) begin
      ma[i] = 0;
      mb[i] = 0;
    end
    ma[0] = -128;
    mb[0] = 127;
    push_exp(32'hFFFFC080, 0);
    for (int i = 1; i < NE; i++) push_exp(0, i);
    load_mats();
    wait_drain("signed");

    // Abort after 20 beats, then a full reload
    set_identity_a();
    for (int i = 0; i < NE; i++) send_beat(ma[i]);
    for (int i = 0; i < 4; i++) send_beat(7);
    rst_n = 1'b0;
    #1;
    check("abort_s_ready", 64'(s_ready), 64'(1));
    check("abort_ctrl_busy", 64'(ctrl_busy), 64'(0));
    check("abort_b_flat", 64'(b_flat[63:0]), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_start", 64'(starts_seen), 64'(4));
    for (int i = 0; i < NE; i++) begin
      mb[i] = 5;
      push_exp(5, i);
    end
    load_mats();
    wait_drain("reload");

    check("total_core_starts", 64'(starts_seen), 64'(5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_stream_ctrl.md
Name: systolic_stream_ctrl

Overview:
Host-side initiator for systolic_top. It accepts a valid/ready element stream carrying matrix A and then matrix B, and packs the elements into a_flat/b_flat. It then pulses start, waits for done, captures c_flat, and serialises C back out as a valid/ready result stream. It replaces the bench-only file loading and is the bridge between the host/DMA interface and the array core.

Parameters:
DATA_W, 8, operand element width (signed)
ACC_W, 32, result element width (signed)
ROWS, 4, rows of A and C
COLS, 4, columns of B and C
K, 4, inner dimension (columns of A, rows of B)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input element valid
s_ready  out  1  input element accepted when s_valid&&s_ready
s_data  in  DATA_W  signed operand element; A row-major, then B row-major
m_valid  out  1  result element valid
m_ready  in  1  downstream accepts result
m_data  out  ACC_W  signed C element, row-major
m_last  out  1  high with final C element (idx ROWS*COLS-1)
core_start  out  1  to systolic_top.start, one-cycle pulse
core_busy  in  1  from systolic_top.busy
core_done  in  1  from systolic_top.done
a_flat  out  ROWS*K*DATA_W  packed A; element (r,c) at bits [(r*K+c+1)*DATA_W-1 -: DATA_W]
b_flat  out  K*COLS*DATA_W  packed B; element (r,c) at bits [(r*COLS+c+1)*DATA_W-1 -: DATA_W]
c_flat  in  ROWS*COLS*ACC_W  packed C from core, same index rule
ctrl_busy  out  1  high in every state except LOAD_A with zero elements received
cycle_count  out  32  start-to-done cycle count (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: state=LOAD_A; all counters 0; a_flat/b_flat/captured C all 0; s_ready=1; m_valid=0; m_last=0; m_data=0; core_start=0; ctrl_busy=0; cycle_count=0.
- LOAD_A: s_ready=1.
  - Each accepted beat writes A element idx, then idx++.
  - On the beat with idx=ROWS*K-1, go to LOAD_B and reset idx to 0.
- LOAD_B: same scheme for B.
  - On the beat with idx=K*COLS-1, go to START.
- START: s_ready=0; core_start=1 for exactly this one cycle; next state WAIT.
  - a_flat/b_flat are stable from the cycle before core_start and held until the next LOAD_A acceptance.
- WAIT: core_start=0.
  - On core_done=1, register c_flat into the internal C buffer and go to DRAIN.
  - core_done outside WAIT is ignored.
  - core_busy is informational only and not required for sequencing.
- DRAIN: m_valid=1 from the first DRAIN cycle; m_data = C[idx]; m_last = (idx==ROWS*COLS-1).
  - m_data/m_last hold stable while m_valid && !m_ready.
  - idx advances on m_valid&&m_ready.
  - The handshake on the last element returns the block to LOAD_A with m_valid=0 the next cycle.
- Latency:
  - Last B beat at cycle t → core_start at t+1.
  - core_done at cycle d → first m_valid at d+1.
- s_ready is 0 in START/WAIT/DRAIN. s_valid there is not consumed; the upstream holds it.
- Widths: elements are copied bit-exact, with no sign extension or saturation; m_data is the raw ACC_W slice.
- Reset mid-operation returns to reset values immediately. A partially loaded matrix is discarded, and no core_start is emitted after the reset.

Optional Feature:
SYSTOLIC_CYCLE_COUNT_EN
- Defined:
  - A 32-bit counter clears on core_start, increments every WAIT cycle, and freezes on core_done.
  - cycle_count holds the frozen value until the next core_start.
  - The counter saturates at 2^32-1.
- Undefined: cycle_count is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package systolic_pkg: state enum (LOAD_A, LOAD_B, START, WAIT, DRAIN); default DATA_W/ACC_W/ROWS/COLS/K localparams; helper functions for flat-index bit offsets.
- One sub-module, systolic_result_serializer. It is parameterised ACC_W and N=ROWS*COLS. It takes the capture pulse plus c_flat and produces m_valid/m_data/m_last with its own index counter. It asserts a drain_done pulse back to the FSM.

Test Plan:
- A=identity, B=1..16 row-major, connected to a real systolic_top → C stream is 1..16 in order; m_last only on 16th; core_start high exactly one cycle, the cycle after the 32nd accepted beat.
- A all 2, B all 3 → all 16 outputs 24; s_ready=0 from START until after the 16th output handshake.
- m_ready toggled 1,0,0,1 repeating during DRAIN → no element dropped or duplicated; m_data stable while stalled; 16 handshakes total.
- Signed: A(0,0)=-128, B(0,0)=127, all other elements 0 → C(0,0)=-16256 (0xFFFFC080), rest 0.
- rst_n low after 20 of 32 input beats, then reload a full A=identity, B=5 everywhere → no core_start during the aborted load; all 16 outputs 5.
- With SYSTOLIC_CYCLE_COUNT_EN defined and a stub core asserting core_done 10 cycles after core_start → cycle_count=10; without the macro → cycle_count=0.
